// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter.
// Chooses the next fetch address from exception, buffered pending redirect,
// branch, jump or sequential increment. A redirect that arrives while the
// stage is stalled is parked in a one-entry buffer and applied on the first
// unstalled edge. Flush, PendingValid and AlignErr are registered; only
// PCPlus is combinational (from the PC register).
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter int                 INCR         = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0180)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             ExcReq,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             JumpReq,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlus,
    output logic             Flush,
    output logic             PendingValid,
    output logic             AlignErr
);

    // Redirect kinds, encoded so that a larger value means a higher priority.
    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_JUMP   = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_EXC    = 2'd3
    } kind_e;

    // Low address bits that must be zero for an aligned target (INCR is a power of two).
    localparam logic [WIDTH-1:0] ALIGN_LSB  = WIDTH'(INCR - 1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~ALIGN_LSB;
    localparam logic [WIDTH-1:0] INCR_W     = WIDTH'(INCR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             pending_valid_q, pending_valid_d;
    kind_e            pending_kind_q, pending_kind_d;
    logic [WIDTH-1:0] pending_target_q, pending_target_d;
    logic             align_err_q, align_err_d;

    kind_e            new_kind;
    logic [WIDTH-1:0] new_target;
    logic             new_misaligned;

    // Pick the highest-priority request arriving this cycle and align its target.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        new_kind       = KIND_NONE;
        new_target     = '0;
        new_misaligned = 1'b0;
        if (ExcReq) begin
            new_kind   = KIND_EXC;
            new_target = EXC_VECTOR;
        end else if (BranchTaken) begin
            new_kind       = KIND_BRANCH;
            new_target     = BranchTarget & ALIGN_MASK;
            new_misaligned = |(BranchTarget & ALIGN_LSB);
        end else if (JumpReq) begin
            new_kind       = KIND_JUMP;
            new_target     = JumpTarget & ALIGN_MASK;
            new_misaligned = |(JumpTarget & ALIGN_LSB);
        end
    end

    // Next-state selection for the PC, the pending buffer and the status flags.
    always_comb begin
        pc_d             = pc_q;
        flush_d          = 1'b0;
        pending_valid_d  = pending_valid_q;
        pending_kind_d   = pending_kind_q;
        pending_target_d = pending_target_q;
        align_err_d      = align_err_q;

        if (!Stall) begin
            // The buffered redirect belongs to an older instruction, so only an
            // exception may pre-empt it.
            if (ExcReq) begin
                pc_d    = EXC_VECTOR;
                flush_d = 1'b1;
            end else if (pending_valid_q) begin
                pc_d    = pending_target_q;
                flush_d = 1'b1;
            end else if (new_kind != KIND_NONE) begin
                pc_d        = new_target;
                flush_d     = 1'b1;
                align_err_d = align_err_q | new_misaligned;
            end else begin
                pc_d = pc_q + INCR_W;
            end
            pending_valid_d = 1'b0;
            pending_kind_d  = KIND_NONE;
        end else if (new_kind != KIND_NONE) begin
            // Overwrite the buffer only with a strictly more important request.
            if (!pending_valid_q || (new_kind > pending_kind_q)) begin
                pending_kind_d   = new_kind;
                pending_target_d = new_target;
                align_err_d      = align_err_q | new_misaligned;
            end
            pending_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q             <= RESET_VECTOR;
            flush_q          <= 1'b0;
            pending_valid_q  <= 1'b0;
            pending_kind_q   <= KIND_NONE;
            pending_target_q <= '0;
            align_err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            pc_q             <= pc_d;
            flush_q          <= flush_d;
            pending_valid_q  <= pending_valid_d;
            pending_kind_q   <= pending_kind_d;
            pending_target_q <= pending_target_d;
            align_err_q      <= align_err_d;
        end
    end

    assign PCResult     = pc_q;
    assign PCPlus       = pc_q + INCR_W;
    assign Flush        = flush_q;
    assign PendingValid = pending_valid_q;
    assign AlignErr     = align_err_q;

endmodule
